// File: rtl/clk_div_switch_ctrl.sv
// Glitch-free divide-factor switch controller: drains the divider to a low phase,
// gates the downstream clock, reloads the factor, lets it settle, then ungates.
module clk_div_switch_ctrl #(
    parameter int unsigned MAX_DIV_FAC = 8,
    parameter int unsigned INIT_DIV    = 2,
    parameter int unsigned SETTLE_CYC  = 4,
    localparam int unsigned W          = $clog2(MAX_DIV_FAC + 1)
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [W-1:0] req_div,
    output logic         req_ready,
    input  logic         div_clk,
    output logic [W-1:0] div_sel,
    output logic         div_rst_n,
    output logic         gate_en,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned DW = $clog2(2 * MAX_DIV_FAC);
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_GATE,
        ST_LOAD,
        ST_SETTLE,
        ST_UNGATE
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  pend, pend_nxt, div_sel_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic [SW-1:0] settle_cnt, settle_cnt_nxt;
    logic          div_clk_q, div_clk_q_nxt;
    logic          init_seq, init_seq_nxt;
    logic          req_ready_nxt, busy_nxt, div_rst_n_nxt, gate_en_nxt;
    logic          done_nxt, err_nxt;

    logic accept, illegal, same, div_fall;
    assign accept   = req_valid && req_ready;
    assign illegal  = req_div > W'(MAX_DIV_FAC);
    assign same     = req_div == div_sel;
    assign div_fall = div_clk_q && !div_clk;

    // State and every output/datapath register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            pend       <= '0;
            drain_cnt  <= '0;
            settle_cnt <= '0;
            div_clk_q  <= 1'b0;
            init_seq   <= 1'b1;
            div_sel    <= W'(INIT_DIV);
            div_rst_n  <= 1'b0;
            gate_en    <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend       <= pend_nxt;
            drain_cnt  <= drain_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            div_clk_q  <= div_clk_q_nxt;
            init_seq   <= init_seq_nxt;
            div_sel    <= div_sel_nxt;
            div_rst_n  <= div_rst_n_nxt;
            gate_en    <= gate_en_nxt;
            req_ready  <= req_ready_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:   state_nxt = ST_SETTLE;
            ST_IDLE: begin
                if (accept && !illegal && !same)
                    state_nxt = (div_sel >= W'(2)) ? ST_DRAIN : ST_GATE;
            end
            ST_DRAIN: begin
                if (div_fall || drain_cnt == DW'(2 * MAX_DIV_FAC - 1))
                    state_nxt = ST_GATE;
            end
            ST_GATE:   state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1))
                    state_nxt = ST_UNGATE;
            end
            ST_UNGATE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_INIT;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        pend_nxt       = pend;
        div_sel_nxt    = div_sel;
        gate_en_nxt    = gate_en;
        req_ready_nxt  = (state_nxt == ST_IDLE);
        busy_nxt       = (state_nxt != ST_IDLE);
        div_rst_n_nxt  = (state_nxt != ST_LOAD);
        err_nxt        = accept && illegal;
        done_nxt       = (state == ST_UNGATE && !init_seq) || (accept && !illegal && same);
        init_seq_nxt   = init_seq && (state != ST_UNGATE);
        div_clk_q_nxt  = (state == ST_DRAIN) ? div_clk : 1'b0;
        drain_cnt_nxt  = (state == ST_DRAIN && state_nxt == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
        settle_cnt_nxt = (state == ST_SETTLE && state_nxt == ST_SETTLE) ? settle_cnt + SW'(1) : '0;

        if (accept && !illegal && !same) pend_nxt = req_div;
        if (state_nxt == ST_LOAD)        div_sel_nxt = pend;
        if (state_nxt == ST_GATE)        gate_en_nxt = 1'b0;
        if (state_nxt == ST_UNGATE)      gate_en_nxt = (div_sel != '0);
    end

endmodule

// File: tb/tb_clk_div_switch_ctrl.sv
// Directed bench for clk_div_switch_ctrl with MAX_DIV_FAC=8, INIT_DIV=2, SETTLE_CYC=4.
module tb_clk_div_switch_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_div;
    logic       req_ready;
    logic       div_clk;
    logic [3:0] div_sel;
    logic       div_rst_n;
    logic       gate_en;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_switch_ctrl #(.MAX_DIV_FAC(8), .INIT_DIV(2), .SETTLE_CYC(4)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .div_clk   (div_clk),
        .div_sel   (div_sel),
        .div_rst_n (div_rst_n),
        .gate_en   (gate_en),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Reset-release sequence: INIT -> SETTLE(4) -> UNGATE -> IDLE, never pulsing done
    task automatic check_init(input string pfx);
        chk({pfx, "_init_rstn_low"}, 32'(div_rst_n), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("%s_init_rstn_c%0d", pfx, k), 32'(div_rst_n), 32'd1);
            chk($sformatf("%s_init_gate_c%0d", pfx, k), 32'(gate_en), (k >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("%s_init_ready_c%0d", pfx, k), 32'(req_ready), (k == 6) ? 32'd1 : 32'd0);
            chk($sformatf("%s_init_done_c%0d", pfx, k), 32'(done), 32'd0);
        end
        chk({pfx, "_init_divsel"}, 32'(div_sel), 32'd2);
        chk({pfx, "_init_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_rst_divsel"}, 32'(div_sel), 32'd2);
        chk({pfx, "_rst_gate"}, 32'(gate_en), 32'd0);
        chk({pfx, "_rst_rstn"}, 32'(div_rst_n), 32'd0);
        chk({pfx, "_rst_ready"}, 32'(req_ready), 32'd0);
        chk({pfx, "_rst_busy"}, 32'(busy), 32'd1);
        chk({pfx, "_rst_done"}, 32'(done), 32'd0);
        chk({pfx, "_rst_err"}, 32'(err), 32'd0);
    endtask

    task automatic request(input logic [3:0] f);
        req_valid = 1'b1;
        req_div   = f;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) tick();
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_div = '0; div_clk = 1'b0;
        tick(); tick();
        check_reset_vals("por");
        rst = 1'b0;
        check_init("por");

        // Switch 2 -> 5 with a real div_clk falling edge inside DRAIN
        div_clk = 1'b1;
        request(4'd5);
        chk("a_busy_acc", 32'(busy), 32'd1);
        chk("a_ready_acc", 32'(req_ready), 32'd0);
        chk("a_gate_acc", 32'(gate_en), 32'd1);
        tick();
        div_clk = 1'b0;
        chk("a_gate_drain", 32'(gate_en), 32'd1);
        tick();
        chk("a_gate_fell", 32'(gate_en), 32'd0);
        tick();
        chk("a_load_divsel", 32'(div_sel), 32'd5);
        chk("a_load_rstn", 32'(div_rst_n), 32'd0);
        req_valid = 1'b1; req_div = 4'd3;
        tick();
        req_valid = 1'b0;
        chk("a_settle_rstn", 32'(div_rst_n), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("a_ungate_gate", 32'(gate_en), 32'd1);
        chk("a_ungate_done", 32'(done), 32'd0);
        tick();
        chk("a_done", 32'(done), 32'd1);
        chk("a_idle_busy", 32'(busy), 32'd0);
        chk("a_idle_ready", 32'(req_ready), 32'd1);
        tick();
        chk("a_done_1cyc", 32'(done), 32'd0);
        chk("a_ignored_busy_req", 32'(div_sel), 32'd5);
        chk("a_stay_idle", 32'(busy), 32'd0);

        // Illegal factor 9
        request(4'd9);
        chk("b_err", 32'(err), 32'd1);
        chk("b_done", 32'(done), 32'd0);
        chk("b_busy", 32'(busy), 32'd0);
        chk("b_divsel", 32'(div_sel), 32'd5);
        tick();
        chk("b_err_1cyc", 32'(err), 32'd0);
        chk("b_gate", 32'(gate_en), 32'd1);

        // Same factor: immediate done, no sequence
        request(4'd5);
        chk("c_done", 32'(done), 32'd1);
        chk("c_err", 32'(err), 32'd0);
        chk("c_busy", 32'(busy), 32'd0);
        tick();
        chk("c_done_1cyc", 32'(done), 32'd0);

        // div_clk stuck low: DRAIN times out after 16 cycles
        div_clk = 1'b0;
        request(4'd3);
        for (int k = 1; k < 16; k++) tick();
        chk("d_gate_c15", 32'(gate_en), 32'd1);
        chk("d_busy_c15", 32'(busy), 32'd1);
        tick();
        chk("d_gate_c16", 32'(gate_en), 32'd0);
        tick();
        chk("d_load_divsel", 32'(div_sel), 32'd3);
        chk("d_load_rstn", 32'(div_rst_n), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("d_done_early", 32'(done), 32'd0);
        tick();
        chk("d_done", 32'(done), 32'd1);

        // Go to 1, then 1 -> 0 skips DRAIN and leaves the gate closed
        request(4'd1);
        wait_done("e_pre_done", 40);
        chk("e_pre_divsel", 32'(div_sel), 32'd1);
        request(4'd0);
        chk("e_gate_direct", 32'(gate_en), 32'd0);
        chk("e_busy", 32'(busy), 32'd1);
        tick();
        chk("e_load_divsel", 32'(div_sel), 32'd0);
        chk("e_load_rstn", 32'(div_rst_n), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("e_ungate_gate", 32'(gate_en), 32'd0);
        chk("e_ungate_done", 32'(done), 32'd0);
        tick();
        chk("e_done", 32'(done), 32'd1);
        chk("e_gate_final", 32'(gate_en), 32'd0);
        tick();
        chk("e_done_once", 32'(done), 32'd0);

        // Reset asserted mid-SETTLE
        request(4'd4);
        tick(); tick();
        chk("f_in_settle_rstn", 32'(div_rst_n), 32'd1);
        chk("f_in_settle_divsel", 32'(div_sel), 32'd4);
        rst = 1'b1;
        #1;
        check_reset_vals("mid");
        tick();
        rst = 1'b0;
        check_init("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
